// File: rtl/dcache_data_sram_ctrl.sv
// rtl/dcache_data_sram_ctrl.sv - D-cache data array port controller with flush sweep
//
// Purpose: initiator for a 1RW SRAM data array. Accepts read and masked-write
// requests, returns read data on a response channel, and runs a full-array
// flush sweep that streams every row out in index order.
//
// Ports:
//   clk0, init                      clock, asynchronous active-high reset
//   req_valid/req_ready/req_*       request channel (we, addr, wmask, wdata)
//   rsp_valid/rsp_ready/rsp_data    read response channel
//   flush_start/busy/done           sweep control and status
//   wb_valid/wb_ready/wb_idx/wb_data  sweep row stream
//   sram_csb0/web0/wmask0/addr0/din0  registered SRAM command outputs
//   sram_dout0                      SRAM read data

module dcache_data_sram_ctrl #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 128,
    parameter int NUM_WMASKS = DATA_WIDTH / 8
) (
    input  logic                  clk0,
    input  logic                  init,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_WMASKS-1:0] req_wmask,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    input  logic                  flush_start,
    output logic                  flush_busy,
    output logic                  flush_done,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [ADDR_WIDTH-1:0] wb_idx,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_WAIT,
        S_RSP,
        S_FL_ISSUE,
        S_FL_WAIT,
        S_FL_HOLD
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ROW = '1;

    state_t                  state_q, state_d;
    logic                    rd_phase_q, rd_phase_d;
    logic [ADDR_WIDTH-1:0]   row_q, row_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic                    wb_valid_q, wb_valid_d;
    logic [ADDR_WIDTH-1:0]   wb_idx_q, wb_idx_d;
    logic [DATA_WIDTH-1:0]   wb_data_q, wb_data_d;
    logic                    flush_busy_q, flush_busy_d;
    logic                    flush_done_q, flush_done_d;
    logic                    sram_csb_q, sram_csb_d;
    logic                    sram_web_q, sram_web_d;
    logic [NUM_WMASKS-1:0]   sram_wmask_q, sram_wmask_d;
    logic [ADDR_WIDTH-1:0]   sram_addr_q, sram_addr_d;
    logic [DATA_WIDTH-1:0]   sram_din_q, sram_din_d;
    logic [ADDR_WIDTH-1:0]   row_next;

    // Flush request takes priority over a simultaneous LSU/MSHR request.
    assign req_ready = (state_q == S_IDLE) && !flush_start && !init;
    assign row_next  = row_q + ADDR_WIDTH'(1);

    always_comb begin
        state_d      = state_q;
        rd_phase_d   = rd_phase_q;
        row_d        = row_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        wb_valid_d   = wb_valid_q;
        wb_idx_d     = wb_idx_q;
        wb_data_d    = wb_data_q;
        flush_busy_d = flush_busy_q;
        flush_done_d = 1'b0;
        // SRAM command is a one-cycle strobe; idle unless a branch issues one.
        sram_csb_d   = 1'b1;
        sram_web_d   = 1'b1;
        sram_wmask_d = sram_wmask_q;
        sram_addr_d  = sram_addr_q;
        sram_din_d   = sram_din_q;

        case (state_q)
            S_IDLE: begin
                if (flush_start) begin
                    // Row 0 read is issued on the way into FL_ISSUE so that
                    // FL_ISSUE is the SRAM latch cycle and a row costs 3 cycles.
                    row_d        = '0;
                    flush_busy_d = 1'b1;
                    sram_csb_d   = 1'b0;
                    sram_addr_d  = '0;
                    sram_wmask_d = '0;
                    state_d      = S_FL_ISSUE;
                end else if (req_valid && req_ready) begin
                    sram_csb_d  = 1'b0;
                    sram_addr_d = req_addr;
                    if (req_we) begin
                        sram_web_d   = 1'b0;
                        sram_wmask_d = req_wmask;
                        sram_din_d   = req_wdata;
                    end else begin
                        sram_wmask_d = '0;
                        rd_phase_d   = 1'b0;
                        state_d      = S_RD_WAIT;
                    end
                end
            end
            S_RD_WAIT: begin
                // First cycle: SRAM latches the command; second: dout is valid.
                if (!rd_phase_q) begin
                    rd_phase_d = 1'b1;
                end else begin
                    rsp_data_d  = sram_dout0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RSP;
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            S_FL_ISSUE: begin
                state_d = S_FL_WAIT;
            end
            S_FL_WAIT: begin
                wb_data_d  = sram_dout0;
                wb_idx_d   = row_q;
                wb_valid_d = 1'b1;
                state_d    = S_FL_HOLD;
            end
            S_FL_HOLD: begin
                if (wb_ready) begin
                    wb_valid_d = 1'b0;
                    if (row_q == LAST_ROW) begin
                        flush_busy_d = 1'b0;
                        flush_done_d = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        row_d        = row_next;
                        sram_csb_d   = 1'b0;
                        sram_addr_d  = row_next;
                        sram_wmask_d = '0;
                        state_d      = S_FL_ISSUE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk0 or posedge init) begin
        if (init) begin
            state_q      <= S_IDLE;
            rd_phase_q   <= 1'b0;
            row_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            wb_valid_q   <= 1'b0;
            wb_idx_q     <= '0;
            wb_data_q    <= '0;
            flush_busy_q <= 1'b0;
            flush_done_q <= 1'b0;
            sram_csb_q   <= 1'b1;
            sram_web_q   <= 1'b1;
            sram_wmask_q <= '0;
            sram_addr_q  <= '0;
            sram_din_q   <= '0;
        end else begin
            state_q      <= state_d;
            rd_phase_q   <= rd_phase_d;
            row_q        <= row_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            wb_valid_q   <= wb_valid_d;
            wb_idx_q     <= wb_idx_d;
            wb_data_q    <= wb_data_d;
            flush_busy_q <= flush_busy_d;
            flush_done_q <= flush_done_d;
            sram_csb_q   <= sram_csb_d;
            sram_web_q   <= sram_web_d;
            sram_wmask_q <= sram_wmask_d;
            sram_addr_q  <= sram_addr_d;
            sram_din_q   <= sram_din_d;
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign wb_valid    = wb_valid_q;
    assign wb_idx      = wb_idx_q;
    assign wb_data     = wb_data_q;
    assign flush_busy  = flush_busy_q;
    assign flush_done  = flush_done_q;
    assign sram_csb0   = sram_csb_q;
    assign sram_web0   = sram_web_q;
    assign sram_wmask0 = sram_wmask_q;
    assign sram_addr0  = sram_addr_q;
    assign sram_din0   = sram_din_q;

endmodule
